// File: rtl/radix_3_in_commutator_if.sv
// Stream-in / triple-out bus of the radix-3 input commutator.
// master drives samples and sees triples; slave is the commutator itself.
interface radix_3_in_commutator_if #(
  parameter int DW = 32,
  parameter int IW = 4
);
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_img;
  logic [DW-1:0] a_re, a_img;
  logic [DW-1:0] b_re, b_img;
  logic [DW-1:0] c_re, c_img;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          frame_err;

  modport master (
    output in_valid, in_sof, in_re, in_img,
    input  a_re, a_img, b_re, b_img, c_re, c_img,
    input  out_valid, out_idx, out_last, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_img,
    output a_re, a_img, b_re, b_img, c_re, c_img,
    output out_valid, out_idx, out_last, frame_err
  );
endinterface

// File: rtl/radix_3_in_commutator.sv
// Radix-3 input commutator: buffers x[0..2M-1] of each frame in two banks and
// emits (x[k], x[k+M], x[k+2M]) as x[k+2M] streams in.
module radix_3_in_commutator #(
  parameter int DW      = 32,
  parameter int SEG_LEN = 9,
  parameter int IW      = $clog2(SEG_LEN)
) (
  input  logic clk,
  input  logic rst_n,
  radix_3_in_commutator_if.slave bus
);

  typedef enum logic [1:0] {FILL_A, FILL_B, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt, wr_idx;
  logic          wr_a, wr_b, emit, err, last;

  logic [2*DW-1:0] bank_a [SEG_LEN];
  logic [2*DW-1:0] bank_b [SEG_LEN];

  logic [DW-1:0] a_re_q, a_img_q, b_re_q, b_img_q, c_re_q, c_img_q;
  logic [IW-1:0] idx_q;
  logic          vld_q, last_q, err_q;

  assign last = (cnt == IW'(SEG_LEN - 1));

  // FSM state and segment counter; only accepted samples move them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL_A;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, bank write selects, triple strobe and sof realignment
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    wr_idx    = cnt;
    emit      = 1'b0;
    err       = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        // sof forces this sample to x[0]; any partial frame is dropped
        wr_a      = 1'b1;
        wr_idx    = '0;
        cnt_nxt   = IW'(1);
        state_nxt = FILL_A;
        err       = (state != FILL_A) || (cnt != '0);
      end else begin
        cnt_nxt = last ? '0 : cnt + IW'(1);
        unique case (state)
          FILL_A: begin
            wr_a = 1'b1;
            if (last) state_nxt = FILL_B;
          end
          FILL_B: begin
            wr_b = 1'b1;
            if (last) state_nxt = DRAIN;
          end
          DRAIN: begin
            emit = 1'b1;
            if (last) state_nxt = FILL_A;
          end
          default: state_nxt = FILL_A;
        endcase
      end
    end
  end

  // Sample banks; never cleared since DRAIN only follows a full rewrite
  always_ff @(posedge clk) begin
    if (wr_a) bank_a[wr_idx] <= {bus.in_re, bus.in_img};
    if (wr_b) bank_b[wr_idx] <= {bus.in_re, bus.in_img};
  end

  // Output triple register; data holds between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_re_q  <= '0;
      a_img_q <= '0;
      b_re_q  <= '0;
      b_img_q <= '0;
      c_re_q  <= '0;
      c_img_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vld_q  <= emit;
      last_q <= emit && last;
      err_q  <= err;
      if (emit) begin
        {a_re_q, a_img_q} <= bank_a[cnt];
        {b_re_q, b_img_q} <= bank_b[cnt];
        c_re_q            <= bus.in_re;
        c_img_q           <= bus.in_img;
        idx_q             <= cnt;
      end
    end
  end

  assign bus.a_re      = a_re_q;
  assign bus.a_img     = a_img_q;
  assign bus.b_re      = b_re_q;
  assign bus.b_img     = b_img_q;
  assign bus.c_re      = c_re_q;
  assign bus.c_img     = c_img_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = vld_q;
  assign bus.out_last  = last_q;
  assign bus.frame_err = err_q;

endmodule
